// File: rtl/enc_mac_seq_ctrl.sv
// Sequencer for one encoder layer's shared MAC array: steps the weight-row index,
// gates accumulator updates on operand availability and holds y until it is taken.
module enc_mac_seq_ctrl #(
  parameter int N_IN  = 10,
  parameter int IDX_W = 4,
  parameter int LAT   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_valid,
  output logic [IDX_W-1:0] idx,
  output logic             acc_load,
  output logic             acc_en,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  localparam int               IDX_LAST_I = N_IN - 1;
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_LAST_I[IDX_W-1:0];
  localparam int               LAT_LAST_I = (LAT > 0) ? LAT - 1 : 0;
  localparam logic [3:0]       LAT_LAST   = LAT_LAST_I[3:0];

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic [3:0]       drain_reg, drain_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      drain_reg <= drain_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    drain_next = drain_reg;
    acc_en     = 1'b0;
    acc_load   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          idx_next   = '0;
        end
      end
      RUN: begin
        // A missing operand simply stalls the pass; nothing advances.
        if (op_valid) begin
          acc_en   = 1'b1;
          acc_load = (idx_reg == '0);
          if (idx_reg == IDX_LAST) begin
            idx_next   = '0;
            state_next = (LAT > 0) ? DRAIN : HOLD;
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_reg == LAT_LAST) begin
          drain_next = '0;
          state_next = HOLD;
        end else begin
          drain_next = drain_reg + 4'd1;
        end
      end
      HOLD: begin
        idx_next = '0;
        if (out_ready) begin
          state_next = start ? RUN : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign idx       = idx_reg;
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == HOLD);

endmodule
